// File: rtl/accum_seq_ctrl.sv
// ============================================================================
// Module   : accum_seq_ctrl
// Brief    : Sequencer for the 4-bit accumulator datapath (DR -> ALU -> BUFF -> AC)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module accum_seq_ctrl #(
    parameter int CNT_W             = 8,
    parameter bit REQUIRE_NEW_INPUT = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req,
    input  logic             op,
    input  logic             same,
    input  logic             cout,
    output logic             ready,
    output logic             ld_dr,
    output logic             ld_buff,
    output logic             ld_ac,
    output logic             alu_op,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXEC   = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic             r_alu_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_op_count;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && req;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are pure decodes of the state register, so clr drops them at once.
    always_comb begin
        w_next  = r_state;
        ready   = 1'b0;
        busy    = 1'b1;
        ld_dr   = 1'b0;
        ld_buff = 1'b0;
        ld_ac   = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (req) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_dr  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                ld_buff = 1'b1;
                w_next  = S_COMMIT;
            end
            S_COMMIT: begin
                ld_ac  = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = REQUIRE_NEW_INPUT ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!same) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_alu_op   <= 1'b0;
            r_carry    <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op <= op;
                r_carry  <= 1'b0;
            end else if (r_state == S_EXEC) begin
                r_carry <= cout;
            end
            if (r_state == S_DONE) begin
                r_op_count <= r_op_count + C_CNT_ONE;
            end
        end
    end

    assign alu_op   = r_alu_op;
    assign carry    = r_carry;
    assign op_count = r_op_count;

endmodule

`default_nettype wire
